// File: rtl/rom_loader.sv
// ============================================================================
// Module   : rom_loader
// Purpose  : Loads a length-prefixed little-endian byte stream into a 32-bit
//            ROM and holds the core in reset until the image is complete.
//            Define LOADER_CHECKSUM_EN to require a trailing 32-bit word sum.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_loader #(
    parameter int          ROM_DEPTH = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        wen_o,
    output logic [31:0] waddr_o,
    output logic [31:0] wdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        core_hold_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        S_CKSUM = 3'd4,
`endif
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(ROM_DEPTH);

    // State entered once the last data word (or an empty image) is handled.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CKSUM;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t      state;
    state_t      next_state;
    logic [1:0]  byte_cnt;
    logic [31:0] shift_word;
    logic [31:0] word_count;
    logic [31:0] idx;
    logic        accept;
    logic        word_done;
    logic        start_ok;
    logic        last_idx;
    logic [31:0] full_word;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum;
`endif

    assign accept    = byte_valid_i && byte_ready_o;
    assign full_word = {byte_data_i, shift_word[31:8]};
    assign word_done = accept && (byte_cnt == 2'd3);
    assign start_ok  = start_i && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign last_idx  = (idx + 32'd1) >= word_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        byte_ready_o = 1'b0;
        wen_o        = 1'b0;
        waddr_o      = 32'd0;
        wdata_o      = 32'd0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        core_hold_o  = 1'b1;
        case (state)
            S_IDLE: begin
                if (start_i) next_state = S_LEN;
            end
            S_LEN: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (word_done) begin
                    if (full_word > DEPTH_W)     next_state = S_ERR;
                    else if (full_word == 32'd0) next_state = S_TAIL;
                    else                         next_state = S_DATA;
                end
            end
            S_DATA: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (word_done) next_state = S_WRITE;
            end
            S_WRITE: begin
                busy_o     = 1'b1;
                wen_o      = 1'b1;
                waddr_o    = BASE_ADDR + (idx << 2);
                wdata_o    = shift_word;
                next_state = last_idx ? S_TAIL : S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CKSUM: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (word_done) next_state = (full_word == sum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                done_o      = 1'b1;
                core_hold_o = 1'b0;
                if (start_i) next_state = S_LEN;
            end
            S_ERR: begin
                err_o = 1'b1;
                if (start_i) next_state = S_LEN;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Bytes shift in from the top so the first byte lands in bits 7:0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byte_cnt   <= 2'd0;
            shift_word <= 32'd0;
            word_count <= 32'd0;
            idx        <= 32'd0;
        end else if (start_ok) begin
            byte_cnt <= 2'd0;
            idx      <= 32'd0;
        end else begin
            if (accept) begin
                byte_cnt   <= byte_cnt + 2'd1;
                shift_word <= full_word;
                if (word_done && (state == S_LEN)) word_count <= full_word;
            end
            if (state == S_WRITE) idx <= idx + 32'd1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum <= 32'd0;
        end else if (start_ok) begin
            sum <= 32'd0;
        end else if (state == S_WRITE) begin
            sum <= sum + shift_word;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rom_loader.sv
// Testbench for rom_loader: table vectors, hand sequences and random sessions
// compared against a byte-stream reference model.
`default_nettype none

module tb_rom_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        bvalid = 1'b0;
    logic [7:0]  bdata = 8'h00;
    logic        byte_ready_o, wen_o, busy_o, done_o, err_o, core_hold_o;
    logic [31:0] waddr_o, wdata_o;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] wq[$];
    logic [63:0] expq[$];
    logic [7:0]  img[$];
    logic [31:0] words[4];

    typedef struct {
        logic [31:0] len;
        logic [31:0] w0, w1, w2, w3;
        int          gaps;
        bit          bad;
        bit          start_mid;
        bit          exp_done;
        bit          exp_err;
        int          exp_nwr;
    } vec_t;

    vec_t tbl[6];

    rom_loader #(.ROM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .byte_valid_i (bvalid),
        .byte_data_i  (bdata),
        .byte_ready_o (byte_ready_o),
        .wen_o        (wen_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .core_hold_o  (core_hold_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wen_o === 1'b1) begin
            wq.push_back({waddr_o, wdata_o});
            check("ready_low_in_write", {31'd0, byte_ready_o}, 32'd0);
        end
    end

    // Reference model: derives the byte image and expected ROM writes/outcome.
    task automatic model_build(input logic [31:0] len, input bit bad,
                               output bit e_done, output bit e_err);
        logic [31:0] s;
        logic [31:0] cs;
        img.delete();
        expq.delete();
        s = 32'd0;
        for (int b = 0; b < 4; b++) img.push_back(len[8*b +: 8]);
        if (len > 32'(DEPTH)) begin
            e_err  = 1'b1;
            e_done = 1'b0;
            return;
        end
        for (int k = 0; k < int'(len); k++) begin
            for (int b = 0; b < 4; b++) img.push_back(words[k][8*b +: 8]);
            expq.push_back({BASE + 32'(4 * k), words[k]});
            s = s + words[k];
        end
`ifdef LOADER_CHECKSUM_EN
        cs = s ^ {31'd0, bad};
        for (int b = 0; b < 4; b++) img.push_back(cs[8*b +: 8]);
        e_err = bad;
`else
        cs = s;
        e_err = 1'b0;
`endif
        e_done = !e_err;
    endtask

    task automatic send(input int gaps, input bit start_mid, input int nsend);
        int i = 0;
        int cyc = 0;
        bit acc;
        bit pulsed = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        while (i < nsend && cyc < 400) begin
            start = 1'b0;
            if (start_mid && !pulsed && i == 5) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            if ((gaps == 1 && (cyc % 2) == 1) || (gaps == 2 && $urandom_range(0, 2) == 0)) begin
                bvalid = 1'b0;
            end else begin
                bvalid = 1'b1;
                bdata  = img[i];
            end
            acc = bvalid && byte_ready_o;
            @(negedge clk);
            if (acc) i++;
            cyc++;
        end
        bvalid = 1'b0;
        start  = 1'b0;
        check("bytes_accepted", 32'(i), 32'(nsend));
    endtask

    task automatic finish_session(input string tag, input bit e_done, input bit e_err, input int e_nwr);
        int w = 0;
        while (!(done_o || err_o) && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_done"}, {31'd0, done_o}, {31'd0, e_done});
        check({tag, "_err"}, {31'd0, err_o}, {31'd0, e_err});
        check({tag, "_hold"}, {31'd0, core_hold_o}, {31'd0, !e_done});
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_nwr"}, 32'(wq.size()), 32'(e_nwr));
        for (int k = 0; k < wq.size() && k < expq.size(); k++) begin
            check({tag, "_waddr"}, wq[k][63:32], expq[k][63:32]);
            check({tag, "_wdata"}, wq[k][31:0], expq[k][31:0]);
        end
        wq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
        check({tag, "_wen"}, {31'd0, wen_o}, 32'd0);
        check({tag, "_waddr"}, waddr_o, 32'd0);
        check({tag, "_wdata"}, wdata_o, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_done"}, {31'd0, done_o}, 32'd0);
        check({tag, "_err"}, {31'd0, err_o}, 32'd0);
        check({tag, "_hold"}, {31'd0, core_hold_o}, 32'd1);
    endtask

    initial begin
        bit ed, ee;
        tbl[0] = '{32'd2, 32'h13, 32'h0010_0093, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        tbl[1] = '{32'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[2] = '{32'd5, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[3] = '{32'd2, 32'h13, 32'h0010_0093, 32'h0, 32'h0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        tbl[4] = '{32'd4, 32'hDEAD_BEEF, 32'h0123_4567, 32'hFFFF_FFFF, 32'h8000_0001,
                   2, 1'b0, 1'b1, 1'b1, 1'b0, 4};
`ifdef LOADER_CHECKSUM_EN
        tbl[5] = '{32'd2, 32'h13, 32'h0010_0093, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 2};
`else
        tbl[5] = '{32'd2, 32'h13, 32'h0010_0093, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 2};
`endif

        #1 rst = 1'b1;
        #2 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            words[0] = tbl[k].w0;
            words[1] = tbl[k].w1;
            words[2] = tbl[k].w2;
            words[3] = tbl[k].w3;
            model_build(tbl[k].len, tbl[k].bad, ed, ee);
            send(tbl[k].gaps, tbl[k].start_mid, img.size());
            finish_session($sformatf("vec%0d", k), tbl[k].exp_done, tbl[k].exp_err, tbl[k].exp_nwr);
            check($sformatf("vec%0d_model", k), {30'd0, ed, ee},
                  {30'd0, tbl[k].exp_done, tbl[k].exp_err});
            if (tbl[k].exp_err && tbl[k].len > 32'(DEPTH)) begin
                // A fresh start pulse out of ERR must reopen a session in LEN.
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("recover_busy", {31'd0, busy_o}, 32'd1);
                check("recover_ready", {31'd0, byte_ready_o}, 32'd1);
                check("recover_err", {31'd0, err_o}, 32'd0);
            end
        end

        // Reset after two data bytes: outputs drop immediately, nothing is written.
        words[0] = 32'h1122_3344;
        words[1] = 32'h5566_7788;
        model_build(32'd2, 1'b0, ed, ee);
        send(0, 1'b0, 6);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_nwr", 32'(wq.size()), 32'd0);
        check("midreset_busy", {31'd0, busy_o}, 32'd0);
        wq.delete();
        model_build(32'd2, 1'b0, ed, ee);
        send(0, 1'b0, img.size());
        finish_session("after_reset", 1'b1, 1'b0, 2);

        for (int r = 0; r < 24; r++) begin
            logic [31:0] len;
            bit bad;
            len = 32'($urandom_range(0, 6));
            for (int k = 0; k < 4; k++) words[k] = $urandom;
            bad = ($urandom_range(0, 3) == 0);
            model_build(len, bad, ed, ee);
            send($urandom_range(0, 2), 1'($urandom_range(0, 1)), img.size());
            finish_session($sformatf("rand%0d", r), ed, ee, expq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 4096, ROM capacity in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; one clock, asynchronous and active-high.
REQ-005 SHALL have port start_i  input  1  begin a load session (pulse).
REQ-006 SHALL have port byte_valid_i  input  1  byte stream valid.
REQ-007 SHALL have port byte_data_i  input  8  byte stream data.
REQ-008 SHALL have port byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port wen_o  output  1  ROM write enable.
REQ-010 SHALL have port waddr_o  output  32  ROM write byte address, word aligned.
REQ-011 SHALL have port wdata_o  output  32  ROM write data.
REQ-012 SHALL have port busy_o  output  1  session in progress.
REQ-013 SHALL have port done_o  output  1  image fully written.
REQ-014 SHALL have port err_o  output  1  session aborted.
REQ-015 SHALL have port core_hold_o  output  1  hold the core in reset; 0 only when done_o=1.

Function
REQ-016 SHALL implement states IDLE, LEN, DATA, WRITE, CKSUM (macro only), DONE, ERR.
REQ-017 SHALL accept a byte only on a cycle where byte_valid_i=1 and byte_ready_o=1; byte_ready_o=1 only in LEN, DATA, CKSUM.
REQ-018 SHALL leave IDLE, DONE or ERR for LEN on start_i=1; start_i in any other state is ignored.
REQ-019 SHALL in LEN assemble 4 bytes little-endian into a 32-bit word count N, then go to DATA.
REQ-020 SHALL go from LEN directly to ERR if N > ROM_DEPTH; no write is issued.
REQ-021 SHALL go from LEN directly to DONE (or CKSUM if enabled) if N = 0.
REQ-022 SHALL in DATA assemble 4 bytes little-endian (first byte -> bits 7:0) and enter WRITE the cycle after the 4th byte is accepted.
REQ-023 SHALL in WRITE drive wen_o=1 for exactly one cycle, waddr_o=BASE_ADDR+4*idx, wdata_o=assembled word, with idx starting at 0 per session.
REQ-024 SHALL after WRITE increment idx and return to DATA if idx<N, else go to DONE (or CKSUM).
REQ-025 SHALL hold wen_o=0 in all states except WRITE; waddr_o and wdata_o are don't-care while wen_o=0.
REQ-026 SHALL drive busy_o=1 in LEN, DATA, WRITE, CKSUM; done_o=1 only in DONE; err_o=1 only in ERR.
REQ-027 SHALL clear the byte-assembly counter and the running sum on every entry to LEN.
REQ-028 SHALL tolerate arbitrary gaps in byte_valid_i without losing or duplicating bytes.

Reset
REQ-029 SHALL on rst_i=1, immediately and asynchronously, enter IDLE with byte_ready_o=0, wen_o=0, waddr_o=0, wdata_o=0, busy_o=0, done_o=0, err_o=0, core_hold_o=1.
REQ-030 SHALL on reset mid-session abandon partial words; words already written stay in ROM, no further write occurs.

Configuration
REQ-031 SHALL, with LOADER_CHECKSUM_EN defined, keep a 32-bit sum (mod 2^32) of all written words and after the last word enter CKSUM, accept 4 bytes little-endian, go to DONE on match, ERR on mismatch.
REQ-032 SHALL, without LOADER_CHECKSUM_EN, omit the CKSUM state and sum logic and go from the last WRITE (or N=0) directly to DONE.

Verification
REQ-033 SHALL test: start, bytes 02 00 00 00 13 00 00 00 93 00 10 00 -> writes (0x0,0x00000013), (0x4,0x00100093), then done_o=1, core_hold_o=0.
REQ-034 SHALL test: N=0 bytes 00 00 00 00 -> no wen_o, done_o=1 (with macro: checksum 00 00 00 00 then done_o=1).
REQ-035 SHALL test: ROM_DEPTH=4, N=5 -> err_o=1, no wen_o, core_hold_o=1; new start_i recovers to LEN.
REQ-036 SHALL test: byte_valid_i toggled 1/0 every cycle during the REQ-033 image -> identical writes, ready low during WRITE.
REQ-037 SHALL test: rst_i asserted after 2 of 4 data bytes -> outputs at reset values same cycle, no write issued.
REQ-038 SHALL test (macro): REQ-033 image with checksum A6 00 10 00 -> done_o=1; checksum A7 00 10 00 -> err_o=1.
